// File: rtl/arb_pkg.sv
// Shared constants and types for the 16-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 16;
  localparam int unsigned IDX_W   = 4;

  // Last-grant pointer value after reset; makes requester 0 the first candidate.
  localparam logic [IDX_W-1:0] PTR_RESET = 4'hF;

  typedef enum logic {IDLE, GRANT} arb_state_t;

endpackage

// File: rtl/decoder_4bit.sv
// 4-to-16 one-hot decoder.
module decoder_4bit
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  output logic [NUM_REQ-1:0] onehot_o
);

  // Set exactly the bit selected by idx_i.
  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with grant hold and optional hold timeout.
// Grant index, valid and timeout are registered; gnt is a masked decode of the index.
module rr_arbiter_16
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  // A zero MAX_HOLD still needs a 1-bit counter to keep the declarations legal.
  localparam int unsigned CntW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CntW-1:0] HoldLast = (MAX_HOLD > 0) ? CntW'(MAX_HOLD - 1) : '0;

  arb_state_t         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [CntW-1:0]    cnt_q;
  logic               valid_q;
  logic               timeout_q;

  logic [IDX_W-1:0]   pick;
  logic               hold_done;
  logic [NUM_REQ-1:0] dec_raw;

  // Rotate so the candidate after ptr sits at bit 0, take the lowest set bit,
  // then undo the rotation. Result is don't-care when r is all zero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0]     s;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     k;
    s   = p + 1'b1;
    dbl = {r, r} >> s;
    rot = dbl[NUM_REQ-1:0];
    k   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) k = IDX_W'(i);
    end
    return k + s;
  endfunction

  // Next grantee candidate and hold-limit detection.
  always_comb begin
    pick      = rr_pick(req, ptr_q);
    hold_done = (MAX_HOLD != 0) && (cnt_q == HoldLast);
  end

  // Arbitration FSM; release takes priority over timeout, no preemption.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= PTR_RESET;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            idx_q   <= pick;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!req[idx_q]) begin
            ptr_q   <= idx_q;
            valid_q <= 1'b0;
            state_q <= IDLE;
          end else if (hold_done) begin
            ptr_q     <= idx_q;
            valid_q   <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else if (MAX_HOLD != 0) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  decoder_4bit u_dec (
    .idx_i    (idx_q),
    .onehot_o (dec_raw)
  );

  assign gnt       = dec_raw & {NUM_REQ{valid_q}};
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule
